// File: rtl/addr_arb_pkg.sv
// Shared types for the RAM address-bus arbiter: FSM states, filter modes and
// the read/write direction encoding used on addr_is_write.
package addr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        DRAIN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_FFT,
        MODE_FIR,
        MODE_IIR
    } mode_e;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/addr_dir_sel.sv
// Picks the direction that owns the address bus this cycle from the two
// eligibility flags and the burst history. Pure combinational.
module addr_dir_sel
    import addr_arb_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int BURST_W   = $clog2(BURST_MAX + 1)
) (
    input  logic               rd_ok,
    input  logic               wr_ok,
    input  logic               last_dir,
    input  logic [BURST_W-1:0] burst,
    output logic               grant,
    output logic               dir
);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant = rd_ok | wr_ok;
        dir   = DIR_RD;
        if (rd_ok && wr_ok) begin
            // Contention: stay with the current owner until it has used a full burst.
            dir = (burst == BURST_W'(BURST_MAX)) ? ~last_dir : last_dir;
        end else if (wr_ok) begin
            dir = DIR_WR;
        end
    end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Shares one registered RAM address bus between the read and write address
// calculators of the active filter and paces each calculator via its pause input.
module addr_bus_arbiter
    import addr_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fft_enable,
    input  logic              fir_enable,
    input  logic              iir_enable,
    input  logic              start,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] fft_read_addr,
    input  logic [ADDR_W-1:0] fft_write_addr,
    input  logic [ADDR_W-1:0] fir_read_addr,
    input  logic [ADDR_W-1:0] fir_write_addr,
    input  logic [ADDR_W-1:0] iir_read_addr,
    input  logic [ADDR_W-1:0] iir_write_addr,
    input  logic              fft_read_done,
    input  logic              fft_write_done,
    input  logic              fir_read_done,
    input  logic              fir_write_done,
    input  logic              iir_read_done,
    input  logic              iir_write_done,
    output logic              fft_read_pause,
    output logic              fft_write_pause,
    output logic              fir_read_pause,
    output logic              fir_write_pause,
    output logic              iir_read_pause,
    output logic              iir_write_pause,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              addr_is_write,
    output logic              busy,
    output logic              job_done,
    output logic              mode_err
);

    localparam int BURST_W = $clog2(BURST_MAX + 1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                last_dir_q, last_dir_d;
    logic                addr_valid_q, addr_valid_d;
    logic                addr_is_write_q, addr_is_write_d;
    logic                mode_err_q, mode_err_d;

    logic                sel_en, sel_rd_done, sel_wr_done;
    logic [ADDR_W-1:0]   sel_rd_addr, sel_wr_addr;
    logic                arb_active, rd_ok, wr_ok, grant, dir;
    logic [2:0]          en_vec;
    logic                en_onehot;
    mode_e               start_mode;
    logic [5:0]          pause_vec;

    assign en_vec = {iir_enable, fir_enable, fft_enable};

    // Calculator signals of the latched filter.
    always_comb begin
        sel_en      = fft_enable;
        sel_rd_done = fft_read_done;
        sel_wr_done = fft_write_done;
        sel_rd_addr = fft_read_addr;
        sel_wr_addr = fft_write_addr;
        case (mode_q)
            MODE_FIR: begin
                sel_en      = fir_enable;
                sel_rd_done = fir_read_done;
                sel_wr_done = fir_write_done;
                sel_rd_addr = fir_read_addr;
                sel_wr_addr = fir_write_addr;
            end
            MODE_IIR: begin
                sel_en      = iir_enable;
                sel_rd_done = iir_read_done;
                sel_wr_done = iir_write_done;
                sel_rd_addr = iir_read_addr;
                sel_wr_addr = iir_write_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        en_onehot  = 1'b0;
        start_mode = MODE_FFT;
        case (en_vec)
            3'b001: begin en_onehot = 1'b1; start_mode = MODE_FFT; end
            3'b010: begin en_onehot = 1'b1; start_mode = MODE_FIR; end
            3'b100: begin en_onehot = 1'b1; start_mode = MODE_IIR; end
            default: ;
        endcase
    end

    // A dropped enable blocks granting in the same cycle the abort is taken.
    assign arb_active = (state_q == ARB) && sel_en;
    assign rd_ok      = arb_active && rd_req && !sel_rd_done;
    assign wr_ok      = arb_active && wr_req && !sel_wr_done && (wr_cnt_q < rd_cnt_q);

    addr_dir_sel #(
        .BURST_MAX (BURST_MAX),
        .BURST_W   (BURST_W)
    ) u_dir_sel (
        .rd_ok    (rd_ok),
        .wr_ok    (wr_ok),
        .last_dir (last_dir_q),
        .burst    (burst_q),
        .grant    (grant),
        .dir      (dir)
    );

    always_comb begin
        pause_vec = '1;
        if (grant) begin
            pause_vec[{mode_q, dir}] = 1'b0;
        end
    end

    assign {iir_write_pause, iir_read_pause, fir_write_pause,
            fir_read_pause, fft_write_pause, fft_read_pause} = pause_vec;

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        rd_cnt_d        = rd_cnt_q;
        wr_cnt_d        = wr_cnt_q;
        addr_d          = addr_q;
        burst_d         = burst_q;
        last_dir_d      = last_dir_q;
        addr_valid_d    = 1'b0;
        addr_is_write_d = addr_is_write_q;
        mode_err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (en_onehot) begin
                        mode_d     = start_mode;
                        rd_cnt_d   = '0;
                        wr_cnt_d   = '0;
                        burst_d    = '0;
                        last_dir_d = DIR_WR;
                        state_d    = ARB;
                    end else begin
                        mode_err_d = 1'b1;
                    end
                end
            end
            ARB: begin
                if (!sel_en) begin
                    mode_err_d = 1'b1;
                    state_d    = IDLE;
                end else if (sel_rd_done && sel_wr_done) begin
                    state_d = DRAIN;
                end else if (grant) begin
                    addr_d          = (dir == DIR_WR) ? sel_wr_addr : sel_rd_addr;
                    addr_valid_d    = 1'b1;
                    addr_is_write_d = dir;
                    if (dir == DIR_WR) wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                    else               rd_cnt_d = rd_cnt_q + ADDR_W'(1);
                    if (dir == last_dir_q) begin
                        burst_d = (burst_q == BURST_W'(BURST_MAX)) ? burst_q
                                                                   : burst_q + BURST_W'(1);
                    end else begin
                        burst_d = BURST_W'(1);
                    end
                    last_dir_d = dir;
                end
            end
            DRAIN: begin
                if (!sel_en) begin
                    mode_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            mode_q          <= MODE_FFT;
            rd_cnt_q        <= '0;
            wr_cnt_q        <= '0;
            addr_q          <= '0;
            burst_q         <= '0;
            last_dir_q      <= DIR_WR;
            addr_valid_q    <= 1'b0;
            addr_is_write_q <= 1'b0;
            mode_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            rd_cnt_q        <= rd_cnt_d;
            wr_cnt_q        <= wr_cnt_d;
            addr_q          <= addr_d;
            burst_q         <= burst_d;
            last_dir_q      <= last_dir_d;
            addr_valid_q    <= addr_valid_d;
            addr_is_write_q <= addr_is_write_d;
            mode_err_q      <= mode_err_d;
        end
    end

    assign addr          = addr_q;
    assign addr_valid    = addr_valid_q;
    assign addr_is_write = addr_is_write_q;
    assign mode_err      = mode_err_q;
    assign busy          = (state_q != IDLE);
    assign job_done      = (state_q == DONE);

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Directed bench for addr_bus_arbiter: simple counting calculators stand in for
// the six address generators; expected addresses and orderings are hand-derived.
module tb_addr_bus_arbiter;
    import addr_arb_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int BURST_MAX = 8;
    localparam logic [31:0] BASE [6] = '{32'h0000_0100, 32'h0000_0900,
                                         32'h0000_1000, 32'h0000_2000,
                                         32'h0000_3000, 32'h0000_4000};

    logic              clk, rst_n;
    logic              fft_enable, fir_enable, iir_enable, start, rd_req, wr_req;
    logic              fft_read_pause, fft_write_pause, fir_read_pause;
    logic              fir_write_pause, iir_read_pause, iir_write_pause;
    logic [ADDR_W-1:0] addr;
    logic              addr_valid, addr_is_write, busy, job_done, mode_err;

    logic [5:0]        pause;
    logic [31:0]       cnt [6];
    logic              model_clr;
    int                rd_len, wr_len;

    int                n_vec = 0;
    int                n_err = 0;
    logic              seq [64];
    int                seq_n;
    int                max_run_g;

    assign pause = {iir_write_pause, iir_read_pause, fir_write_pause,
                    fir_read_pause, fft_write_pause, fft_read_pause};

    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (model_clr)      cnt[i] <= '0;
            else if (!pause[i]) cnt[i] <= cnt[i] + 1;
        end
    end

    addr_bus_arbiter #(.ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fft_enable      (fft_enable),
        .fir_enable      (fir_enable),
        .iir_enable      (iir_enable),
        .start           (start),
        .rd_req          (rd_req),
        .wr_req          (wr_req),
        .fft_read_addr   (BASE[0] + cnt[0]),
        .fft_write_addr  (BASE[1] + cnt[1]),
        .fir_read_addr   (BASE[2] + cnt[2]),
        .fir_write_addr  (BASE[3] + cnt[3]),
        .iir_read_addr   (BASE[4] + cnt[4]),
        .iir_write_addr  (BASE[5] + cnt[5]),
        .fft_read_done   (cnt[0] >= 32'(rd_len)),
        .fft_write_done  (cnt[1] >= 32'(wr_len)),
        .fir_read_done   (cnt[2] >= 32'(rd_len)),
        .fir_write_done  (cnt[3] >= 32'(wr_len)),
        .iir_read_done   (cnt[4] >= 32'(rd_len)),
        .iir_write_done  (cnt[5] >= 32'(wr_len)),
        .fft_read_pause  (fft_read_pause),
        .fft_write_pause (fft_write_pause),
        .fir_read_pause  (fir_read_pause),
        .fir_write_pause (fir_write_pause),
        .iir_read_pause  (iir_read_pause),
        .iir_write_pause (iir_write_pause),
        .addr            (addr),
        .addr_valid      (addr_valid),
        .addr_is_write   (addr_is_write),
        .busy            (busy),
        .job_done        (job_done),
        .mode_err        (mode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // en = {iir, fir, fft}; returns at the negedge after the start edge.
    task automatic start_job(input logic [2:0] en);
        {iir_enable, fir_enable, fft_enable} = en;
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Follows a job to completion, checking addresses, ordering and the done pulse.
    task automatic run_job(input int m, input int rd_start, input int exp_rd,
                           input int exp_wr, input int max_cycles);
        int   rd_seen, wr_seen, run, jd;
        logic last;
        bit   finished;
        rd_seen = rd_start; wr_seen = 0; run = 0; jd = 0;
        last = DIR_RD; finished = 1'b0; seq_n = 0; max_run_g = 0;
        for (int i = 0; i < max_cycles && !finished; i++) begin
            tick();
            if (addr_valid) begin
                if (addr_is_write) begin
                    check("wr_order", 32'(wr_seen < rd_seen), 32'd1);
                    check("wr_addr", addr, BASE[2*m+1] + 32'(wr_seen));
                    wr_seen++;
                end else begin
                    check("rd_addr", addr, BASE[2*m] + 32'(rd_seen));
                    rd_seen++;
                end
                run  = (seq_n > 0 && addr_is_write == last) ? run + 1 : 1;
                last = addr_is_write;
                if (run > max_run_g) max_run_g = run;
                if (seq_n < 64) seq[seq_n] = addr_is_write;
                seq_n++;
            end
            if (job_done) begin
                check("done_valid", 32'(addr_valid), 32'd0);
                jd++;
            end else if (jd > 0) begin
                finished = 1'b1;
            end
        end
        check("rd_total", 32'(rd_seen), 32'(exp_rd));
        check("wr_total", 32'(wr_seen), 32'(exp_wr));
        check("burst_limit", 32'(max_run_g <= BURST_MAX), 32'd1);
        check("job_done_cycles", 32'(jd), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("pause_after", 32'(pause), 32'h3F);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        fft_enable = 1'b0; fir_enable = 1'b0; iir_enable = 1'b0;
        model_clr = 1'b1; rd_len = 4; wr_len = 4;
        #1 rst_n = 1'b0;
        #1;
        check("rst_pause", 32'(pause), 32'h3F);
        check("rst_addr", addr, 32'h0);
        check("rst_valid", 32'(addr_valid), 32'd0);
        check("rst_is_write", 32'(addr_is_write), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_job_done", 32'(job_done), 32'd0);
        check("rst_mode_err", 32'(mode_err), 32'd0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // FIR, reads only: four grants at one per cycle, then stall on rd_done.
        rd_req = 1'b1; wr_req = 1'b0; rd_len = 4; wr_len = 4;
        start_job(3'b010);
        check("fir_first_grant", 32'(pause), 32'h3B);
        check("fir_lat_valid", 32'(addr_valid), 32'd0);
        check("fir_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fir_rd_valid", 32'(addr_valid), 32'd1);
            check("fir_rd_addr", addr, 32'h1000 + 32'(k));
            check("fir_rd_dir", 32'(addr_is_write), 32'd0);
        end
        check("fir_stall_pause", 32'(pause), 32'h3F);
        tick();
        check("fir_stall_valid", 32'(addr_valid), 32'd0);
        check("fir_stall_busy", 32'(busy), 32'd1);
        wr_req = 1'b1;
        run_job(1, 4, 4, 4, 50);
        fir_enable = 1'b0;

        // Illegal starts: two enables, then none.
        fft_enable = 1'b1; fir_enable = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("err2_pulse", 32'(mode_err), 32'd1);
        check("err2_busy", 32'(busy), 32'd0);
        check("err2_pause", 32'(pause), 32'h3F);
        tick();
        check("err2_clear", 32'(mode_err), 32'd0);
        check("err2_idle", 32'(busy), 32'd0);
        fft_enable = 1'b0; fir_enable = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("err0_pulse", 32'(mode_err), 32'd1);

        // FFT, both directions always requesting: 8R 8W 8R 8W 4R 4W.
        rd_req = 1'b1; wr_req = 1'b1; rd_len = 20; wr_len = 20;
        start_job(3'b001);
        run_job(0, 0, 20, 20, 100);
        check("fft_max_run", 32'(max_run_g), 32'd8);
        check("fft_seq0", 32'(seq[0]), 32'(DIR_RD));
        check("fft_seq7", 32'(seq[7]), 32'(DIR_RD));
        check("fft_seq8", 32'(seq[8]), 32'(DIR_WR));
        check("fft_seq15", 32'(seq[15]), 32'(DIR_WR));
        check("fft_seq16", 32'(seq[16]), 32'(DIR_RD));
        check("fft_seq24", 32'(seq[24]), 32'(DIR_WR));
        check("fft_seq32", 32'(seq[32]), 32'(DIR_RD));
        check("fft_seq36", 32'(seq[36]), 32'(DIR_WR));
        fft_enable = 1'b0;

        // IIR job aborted by dropping its enable.
        start_job(3'b100);
        repeat (5) tick();
        check("iir_busy", 32'(busy), 32'd1);
        iir_enable = 1'b0;
        #1;
        check("abort_pause", 32'(pause), 32'h3F);
        tick();
        check("abort_mode_err", 32'(mode_err), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(addr_valid), 32'd0);
        tick();
        check("abort_err_clear", 32'(mode_err), 32'd0);
        check("abort_pause_idle", 32'(pause), 32'h3F);

        // Asynchronous reset in the middle of an FFT read burst.
        start_job(3'b001);
        repeat (6) tick();
        check("pre_rst_valid", 32'(addr_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_addr", addr, 32'h0);
        check("mid_rst_valid", 32'(addr_valid), 32'd0);
        check("mid_rst_is_write", 32'(addr_is_write), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pause", 32'(pause), 32'h3F);
        check("mid_rst_job_done", 32'(job_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fft_enable = 1'b0;

        // Recovery: a fresh FIR job completes normally.
        rd_len = 3; wr_len = 3;
        start_job(3'b010);
        run_job(1, 0, 3, 3, 50);
        fir_enable = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
